// File: rtl/multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// multicycle_main_controller
//
// Main control FSM of the multicycle RISC-V core. Each instruction is walked
// through fetch / decode / execute / memory / writeback. The machine drives the
// datapath enables and mux selects, and produces the 2-bit ALUOp that the ALU
// decoder downstream consumes.
//
// Outputs are Moore-style: they depend on the registered state only. The one
// exception is FETCH, where ir_write/pc_update also depend on the wait counter.
// pc_write additionally folds in the ALU zero flag for branches.
//
// Parameter:
//   FETCH_WAIT   extra FETCH cycles before instruction/PC capture (0..15)
//
// Optional build macro:
//   ILLEGAL_TRAP_EN   when defined, an unknown opcode in DECODE parks the FSM
//                     in ILLEGAL (illegal=1, all enables 0) until reset.
//                     When undefined, an unknown opcode behaves as a NOP and
//                     illegal is tied to 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   op[6:0]     in   opcode field of the instruction register
//   zero        in   ALU zero flag
//   alu_op      out  00 add, 01 sub (beq), 10 funct-decoded
//   alu_src_a   out  00 PC, 01 OldPC, 10 RD1
//   alu_src_b   out  00 RD2, 01 ImmExt, 10 constant 4
//   result_src  out  00 ALUOut, 01 memory data, 10 ALUResult
//   adr_src     out  memory address mux: 0 PC, 1 Result
//   ir_write    out  instruction register load enable
//   pc_update   out  unconditional PC write request
//   branch      out  branch-evaluate flag
//   pc_write    out  pc_update | (branch & zero)
//   reg_write   out  register file write enable
//   mem_write   out  data memory write enable
//   illegal     out  illegal-opcode trap flag
// -----------------------------------------------------------------------------
module multicycle_main_controller #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
`else
        S_JAL      = 4'd10
`endif
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;

    // Raw enables before reset gating.
    logic ir_write_int, pc_update_int, branch_int, reg_write_int, mem_write_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        wait_cnt_next = '0;   // counter is only nonzero while in FETCH
        alu_op        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        adr_src       = 1'b0;
        ir_write_int  = 1'b0;
        pc_update_int = 1'b0;
        branch_int    = 1'b0;
        reg_write_int = 1'b0;
        mem_write_int = 1'b0;

        case (state_reg)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (wait_cnt_reg == FETCH_LAST) begin
                    ir_write_int  = 1'b1;
                    pc_update_int = 1'b1;
                    state_next    = S_DECODE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                    state_next    = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target OldPC + imm.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_IALU:      state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_next = S_ILLEGAL;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_int = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_int = 1'b1;
                state_next    = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_int = 1'b1;
                state_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch_int = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // Link value PC+4 is formed as OldPC + 4; jump target came from DECODE.
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b10;
                pc_update_int = 1'b1;
                state_next    = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL: begin
                state_next = S_ILLEGAL;   // only reset leaves the trap
            end
`endif
            default: begin
                state_next = S_FETCH;     // unreachable encodings recover
            end
        endcase
    end

    // Enables are gated by rst_n so nothing is written while reset is low,
    // even though FETCH (the reset state) would otherwise assert ir_write.
    assign ir_write  = rst_n & ir_write_int;
    assign pc_update = rst_n & pc_update_int;
    assign branch    = rst_n & branch_int;
    assign pc_write  = rst_n & (pc_update_int | (branch_int & zero));
    assign reg_write = rst_n & reg_write_int;
    assign mem_write = rst_n & mem_write_int;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = rst_n & (state_reg == S_ILLEGAL);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_controller
//
// Two controller instances: dut0 with FETCH_WAIT=0 and dut2 with FETCH_WAIT=2.
// Each record names the state the controller should be in for one cycle;
// expected outputs for that state are pushed to a scoreboard when the inputs
// are driven and popped and compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_main_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IA   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD0 = 7'b0000000;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic       adr;
        logic       irw;
        logic       pcu;
        logic       br;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } out_t;

    typedef enum int {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB,
                      T_BEQ, T_JAL, T_ILL} tst_t;

    typedef struct {
        int         dut;
        logic [6:0] op;
        logic       z;
        tst_t       st;
        logic       last;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, rst_n2, zero0, zero2;
    logic [6:0] op0, op2;

    logic [1:0] alu_op0, src_a0, src_b0, res0, alu_op2, src_a2, src_b2, res2;
    logic adr0, irw0, pcu0, br0, pcw0, rw0, mw0, ill0;
    logic adr2, irw2, pcu2, br2, pcw2, rw2, mw2, ill2;

    out_t act0, act2;
    assign act0 = {alu_op0, src_a0, src_b0, res0, adr0, irw0, pcu0, br0, pcw0, rw0, mw0, ill0};
    assign act2 = {alu_op2, src_a2, src_b2, res2, adr2, irw2, pcu2, br2, pcw2, rw2, mw2, ill2};

    multicycle_main_controller #(.FETCH_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n0), .op(op0), .zero(zero0),
        .alu_op(alu_op0), .alu_src_a(src_a0), .alu_src_b(src_b0),
        .result_src(res0), .adr_src(adr0), .ir_write(irw0),
        .pc_update(pcu0), .branch(br0), .pc_write(pcw0),
        .reg_write(rw0), .mem_write(mw0), .illegal(ill0)
    );

    multicycle_main_controller #(.FETCH_WAIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .op(op2), .zero(zero2),
        .alu_op(alu_op2), .alu_src_a(src_a2), .alu_src_b(src_b2),
        .result_src(res2), .adr_src(adr2), .ir_write(irw2),
        .pc_update(pcu2), .branch(br2), .pc_write(pcw2),
        .reg_write(rw2), .mem_write(mw2), .illegal(ill2)
    );

    int   checks   = 0;
    int   failures = 0;
    out_t sb[$];
    rec_t tbl[$];

    // Output table per state, written from the state/output list.
    function automatic out_t exp_out(input tst_t st, input logic z, input logic last);
        out_t o;
        o = '0;
        case (st)
            T_F:   begin o.src_b = 2'b10; o.res = 2'b10; o.irw = last; o.pcu = last; end
            T_D:   begin o.src_a = 2'b01; o.src_b = 2'b01; end
            T_MA:  begin o.src_a = 2'b10; o.src_b = 2'b01; end
            T_MR:  begin o.adr = 1'b1; end
            T_MWB: begin o.res = 2'b01; o.rw = 1'b1; end
            T_MW:  begin o.adr = 1'b1; o.mw = 1'b1; end
            T_ER:  begin o.src_a = 2'b10; o.alu_op = 2'b10; end
            T_EI:  begin o.src_a = 2'b10; o.src_b = 2'b01; o.alu_op = 2'b10; end
            T_AWB: begin o.rw = 1'b1; end
            T_BEQ: begin o.src_a = 2'b10; o.alu_op = 2'b01; o.br = 1'b1; end
            T_JAL: begin o.src_a = 2'b01; o.src_b = 2'b10; o.pcu = 1'b1; end
            T_ILL: begin o.ill = 1'b1; end
            default: o = '0;
        endcase
        o.pcw = o.pcu | (o.br & z);
        return o;
    endfunction

    function automatic rec_t mk(input int d, input logic [6:0] op, input logic z,
                                input tst_t st, input logic last);
        rec_t r;
        r.dut = d; r.op = op; r.z = z; r.st = st; r.last = last;
        return r;
    endfunction

    // Called at posedge+1: drive inputs, queue expectation, compare at negedge.
    task automatic step(input rec_t r);
        out_t  got, want;
        string nm;
        if (r.dut == 0) begin op0 = r.op; zero0 = r.z; end
        else            begin op2 = r.op; zero2 = r.z; end
        sb.push_back(exp_out(r.st, r.z, r.last));
        @(negedge clk);
        got  = (r.dut == 0) ? act0 : act2;
        want = sb.pop_front();
        nm   = r.st.name();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL dut%0d state=%s op=%b z=%b: got=%h want=%h", r.dut, nm, r.op, r.z, got, want);
        end else begin
            $display("ok   dut%0d state=%s op=%b z=%b out=%h", r.dut, nm, r.op, r.z, got);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string nm, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
        end else begin
            $display("ok   %s out=%h", nm, got);
        end
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n2 = 1'b0;
        op0 = LW; op2 = SW; zero0 = 1'b1; zero2 = 1'b0;

        // Reset state: enables 0 (despite zero=1), selects at FETCH values.
        #3;
        check_now("reset_initial", act0, exp_out(T_F, 1'b1, 1'b0));
        @(negedge clk);
        check_now("reset_held", act0, exp_out(T_F, 1'b1, 1'b0));
        @(posedge clk);
        #1 rst_n0 = 1'b1;

        // ---- FETCH_WAIT = 0 main table ----
        // lw, with op changed to R-type during MEMREAD/MEMWB (must be ignored)
        tbl.push_back(mk(0, LW,  1'b0, T_F,   1'b1));
        tbl.push_back(mk(0, LW,  1'b0, T_D,   1'b0));
        tbl.push_back(mk(0, LW,  1'b0, T_MA,  1'b0));
        tbl.push_back(mk(0, RT,  1'b0, T_MR,  1'b0));
        tbl.push_back(mk(0, RT,  1'b0, T_MWB, 1'b0));
        // R-type
        tbl.push_back(mk(0, RT,  1'b0, T_F,   1'b1));
        tbl.push_back(mk(0, RT,  1'b0, T_D,   1'b0));
        tbl.push_back(mk(0, RT,  1'b0, T_ER,  1'b0));
        tbl.push_back(mk(0, RT,  1'b0, T_AWB, 1'b0));
        // I-ALU
        tbl.push_back(mk(0, IA,  1'b0, T_F,   1'b1));
        tbl.push_back(mk(0, IA,  1'b0, T_D,   1'b0));
        tbl.push_back(mk(0, IA,  1'b0, T_EI,  1'b0));
        tbl.push_back(mk(0, IA,  1'b0, T_AWB, 1'b0));
        // beq taken (zero held 1 throughout; pc_write only in BEQ and FETCH)
        tbl.push_back(mk(0, BEQ, 1'b1, T_F,   1'b1));
        tbl.push_back(mk(0, BEQ, 1'b1, T_D,   1'b0));
        tbl.push_back(mk(0, BEQ, 1'b1, T_BEQ, 1'b0));
        // beq not taken
        tbl.push_back(mk(0, BEQ, 1'b0, T_F,   1'b1));
        tbl.push_back(mk(0, BEQ, 1'b0, T_D,   1'b0));
        tbl.push_back(mk(0, BEQ, 1'b0, T_BEQ, 1'b0));
        // jal
        tbl.push_back(mk(0, JAL, 1'b1, T_F,   1'b1));
        tbl.push_back(mk(0, JAL, 1'b1, T_D,   1'b0));
        tbl.push_back(mk(0, JAL, 1'b0, T_JAL, 1'b0));
        tbl.push_back(mk(0, JAL, 1'b1, T_AWB, 1'b0));
`ifndef ILLEGAL_TRAP_EN
        // unknown opcode acts as a 2-cycle NOP
        tbl.push_back(mk(0, BAD0, 1'b0, T_F,  1'b1));
        tbl.push_back(mk(0, BAD0, 1'b0, T_D,  1'b0));
`endif
        // sw, interrupted by reset in MEMWRITE below
        tbl.push_back(mk(0, SW,  1'b0, T_F,   1'b1));
        tbl.push_back(mk(0, SW,  1'b0, T_D,   1'b0));
        tbl.push_back(mk(0, SW,  1'b0, T_MA,  1'b0));
        for (int i = 0; i < tbl.size() - 1; i++) step(tbl[i]);

        // Last record (MEMADR) done by hand so we stay inside MEMWRITE after it.
        step(tbl[tbl.size() - 1]);
        op0 = SW; zero0 = 1'b0;
        @(negedge clk);
        check_now("sw_memwrite", act0, exp_out(T_MW, 1'b0, 1'b0));
        #2 rst_n0 = 1'b0;
        #1 check_now("async_reset_in_memwrite", act0, exp_out(T_F, 1'b0, 1'b0));
        @(posedge clk);
        #2 check_now("reset_held_over_edge", act0, exp_out(T_F, 1'b0, 1'b0));
        @(negedge clk);
        #1 rst_n0 = 1'b1;
        #1 check_now("release_in_fetch", act0, exp_out(T_F, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        step(mk(0, SW, 1'b0, T_D,  1'b0));
        step(mk(0, SW, 1'b0, T_MA, 1'b0));
        step(mk(0, SW, 1'b0, T_MW, 1'b0));
        step(mk(0, LW, 1'b0, T_F,  1'b1));

        // ---- FETCH_WAIT = 2: sw then R-type ----
        rst_n2 = 1'b1;
        step(mk(2, SW, 1'b1, T_F,   1'b0));
        step(mk(2, SW, 1'b1, T_F,   1'b0));
        step(mk(2, SW, 1'b1, T_F,   1'b1));
        step(mk(2, SW, 1'b0, T_D,   1'b0));
        step(mk(2, SW, 1'b0, T_MA,  1'b0));
        step(mk(2, SW, 1'b0, T_MW,  1'b0));
        step(mk(2, RT, 1'b0, T_F,   1'b0));
        step(mk(2, RT, 1'b0, T_F,   1'b0));
        step(mk(2, RT, 1'b0, T_F,   1'b1));
        step(mk(2, RT, 1'b0, T_D,   1'b0));
        step(mk(2, RT, 1'b0, T_ER,  1'b0));
        step(mk(2, RT, 1'b0, T_AWB, 1'b0));
        step(mk(2, LW, 1'b0, T_F,   1'b0));

`ifdef ILLEGAL_TRAP_EN
        // Illegal opcode on dut0: trap holds until reset regardless of op/zero.
        // dut0 has kept cycling; restart it cleanly first.
        rst_n0 = 1'b0;
        #2 rst_n0 = 1'b1;
        step(mk(0, 7'b1111111, 1'b1, T_F,   1'b1));
        step(mk(0, 7'b1111111, 1'b1, T_D,   1'b0));
        step(mk(0, 7'b1111111, 1'b1, T_ILL, 1'b0));
        step(mk(0, LW,         1'b1, T_ILL, 1'b0));
        step(mk(0, BEQ,        1'b1, T_ILL, 1'b0));
        rst_n0 = 1'b0;
        #1 check_now("illegal_cleared_by_reset", act0, exp_out(T_F, 1'b0, 1'b0));
        @(posedge clk);
        #1 rst_n0 = 1'b1;
        step(mk(0, RT, 1'b0, T_F, 1'b1));
        step(mk(0, RT, 1'b0, T_D, 1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
